// File: rtl/calc_seq_ctrl_if.sv
// Keypad / ALU / display signal bundle for the calculator sequencer.
// master = sequencer side, slave = keypad decoder, ALU and display driver side.
interface calc_seq_ctrl_if #(
    parameter int unsigned DIGIT_NUM = 8
);
    localparam int unsigned W = 4 * DIGIT_NUM;

    logic         key_valid;
    logic         key_type;
    logic [3:0]   key;
    logic [W-1:0] alu_result;
    logic         alu_result_sign;
    logic         alu_flag_ov;
    logic [W-1:0] operand0;
    logic [W-1:0] operand1;
    logic         operand0_sign;
    logic         operand1_sign;
    logic [2:0]   operation;
    logic [W-1:0] disp_num;
    logic         disp_sign;
    logic         disp_mode;
    logic         disp_latch;
    logic [3:0]   brightness;
    logic [3:0]   state_led;

    modport master (
        input  key_valid, key_type, key, alu_result, alu_result_sign, alu_flag_ov,
        output operand0, operand1, operand0_sign, operand1_sign, operation,
               disp_num, disp_sign, disp_mode, disp_latch, brightness, state_led
    );

    modport slave (
        output key_valid, key_type, key, alu_result, alu_result_sign, alu_flag_ov,
        input  operand0, operand1, operand0_sign, operand1_sign, operation,
               disp_num, disp_sign, disp_mode, disp_latch, brightness, state_led
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: BCD operand entry, op chaining, ALU wait, error and brightness menu.
// Define CALC_MEMORY_EN to add the store (E) / recall (D) memory register in the menu.
module calc_seq_ctrl #(
    parameter int unsigned DIGIT_NUM   = 8,
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned BRIGHT_RST  = 4
) (
    input  logic            clock,
    input  logic            reset,
    calc_seq_ctrl_if.master bus
);
    localparam int unsigned W  = 4 * DIGIT_NUM;
    localparam int unsigned CW = $clog2(DIGIT_NUM + 1);
    localparam int unsigned LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(DIGIT_NUM);
    localparam logic [LW-1:0] WAIT_LAST = LW'(ALU_LATENCY - 1);
    localparam logic [3:0] K_A = 4'hA, K_B = 4'hB, K_C = 4'hC, K_D = 4'hD, K_E = 4'hE, K_F = 4'hF;
    localparam logic [2:0] OP_SUM = 3'b000, OP_SUB = 3'b001;

    typedef enum logic [2:0] {S_LOAD_OP0, S_LOAD_OP1, S_WAIT_ALU, S_MENU, S_ERROR} state_t;

    state_t        state, state_d;
    logic [W-1:0]  op0_q, op0_d, op1_q, op1_d, disp_num_q, disp_num_d;
    logic          sign0_q, sign0_d, sign1_q, sign1_d;
    logic [2:0]    oper_q, oper_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [LW-1:0] wait_q, wait_d;
    logic          pend_q, pend_d, pend_sub_q, pend_sub_d, ret_op1_q, ret_op1_d;
    logic          armed_q;
    logic          disp_sign_q, disp_sign_d, disp_mode_q, disp_mode_d, latch_q, latch_d;
    logic [3:0]    bright_q, bright_d, led_q, led_d;
`ifdef CALC_MEMORY_EN
    logic [W-1:0]  mem_q, mem_d;
    logic          mem_sign_q, mem_sign_d;
`endif

    logic          accept, is_digit, sel_op1, clear_req;
    logic [W-1:0]  cur_op;
    logic [CW-1:0] cur_cnt;
    logic          cur_sign;

    assign bus.operand0      = op0_q;
    assign bus.operand1      = op1_q;
    assign bus.operand0_sign = sign0_q;
    assign bus.operand1_sign = sign1_q;
    assign bus.operation     = oper_q;
    assign bus.disp_num      = disp_num_q;
    assign bus.disp_sign     = disp_sign_q;
    assign bus.disp_mode     = disp_mode_q;
    assign bus.disp_latch    = latch_q;
    assign bus.brightness    = bright_q;
    assign bus.state_led     = led_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_LOAD_OP0;
        else       state <= state_d;
    end

    // Next state, datapath updates and registered output values
    always_comb begin
        state_d     = state;
        op0_d       = op0_q;
        op1_d       = op1_q;
        sign0_d     = sign0_q;
        sign1_d     = sign1_q;
        oper_d      = oper_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        wait_d      = wait_q;
        pend_d      = pend_q;
        pend_sub_d  = pend_sub_q;
        ret_op1_d   = ret_op1_q;
        bright_d    = bright_q;
        latch_d     = 1'b0;
        clear_req   = 1'b0;
`ifdef CALC_MEMORY_EN
        mem_d       = mem_q;
        mem_sign_d  = mem_sign_q;
`endif
        accept      = bus.key_valid && armed_q;
        is_digit    = bus.key_type && (bus.key <= 4'd9);
        sel_op1     = (state == S_LOAD_OP1);
        cur_op      = sel_op1 ? op1_q : op0_q;
        cur_cnt     = sel_op1 ? cnt1_q : cnt0_q;
        cur_sign    = sel_op1 ? sign1_q : sign0_q;

        case (state)
            S_LOAD_OP0, S_LOAD_OP1: begin
                if (accept) begin
                    if (is_digit) begin
                        if (cur_cnt < CNT_FULL) begin
                            cur_op  = {cur_op[W-5:0], bus.key};
                            cur_cnt = cur_cnt + CW'(1);
                            latch_d = 1'b1;
                        end
                    end else if (!bus.key_type) begin
                        case (bus.key)
                            K_E: if (cur_cnt != '0) begin
                                cur_op  = {4'h0, cur_op[W-1:4]};
                                cur_cnt = cur_cnt - CW'(1);
                                latch_d = 1'b1;
                            end
                            K_A, K_B: begin
                                latch_d = 1'b1;
                                if (cur_op == '0) begin
                                    cur_sign = !cur_sign;
                                end else if (!sel_op1) begin
                                    oper_d  = (bus.key == K_B) ? OP_SUB : OP_SUM;
                                    state_d = S_LOAD_OP1;
                                end else begin
                                    pend_d     = 1'b1;
                                    pend_sub_d = (bus.key == K_B);
                                    wait_d     = '0;
                                    state_d    = S_WAIT_ALU;
                                end
                            end
                            K_D: if (sel_op1 && (cur_op != '0)) begin
                                pend_d  = 1'b0;
                                wait_d  = '0;
                                state_d = S_WAIT_ALU;
                                latch_d = 1'b1;
                            end
                            K_C: clear_req = 1'b1;
                            K_F: begin
                                ret_op1_d = sel_op1;
                                state_d   = S_MENU;
                                latch_d   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                if (sel_op1) begin
                    op1_d = cur_op; cnt1_d = cur_cnt; sign1_d = cur_sign;
                end else begin
                    op0_d = cur_op; cnt0_d = cur_cnt; sign0_d = cur_sign;
                end
            end
            S_WAIT_ALU: begin
                if (wait_q == WAIT_LAST) begin
                    latch_d = 1'b1;
                    if (bus.alu_flag_ov) begin
                        state_d = S_ERROR;
                    end else begin
                        op0_d   = bus.alu_result;
                        sign0_d = bus.alu_result_sign;
                        cnt0_d  = CNT_FULL;
                        op1_d   = '0;
                        sign1_d = 1'b0;
                        cnt1_d  = '0;
                        pend_d  = 1'b0;
                        if (pend_q) begin
                            oper_d  = pend_sub_q ? OP_SUB : OP_SUM;
                            state_d = S_LOAD_OP1;
                        end else begin
                            state_d = S_LOAD_OP0;
                        end
                    end
                end else begin
                    wait_d = wait_q + LW'(1);
                end
            end
            S_MENU: begin
                if (accept) begin
                    if (is_digit && (bus.key <= 4'd7)) begin
                        bright_d = {bus.key[2:0], 1'b0};
                        latch_d  = 1'b1;
                    end else if (!bus.key_type && (bus.key == K_F)) begin
                        state_d = ret_op1_q ? S_LOAD_OP1 : S_LOAD_OP0;
                        latch_d = 1'b1;
                    end else if (!bus.key_type && (bus.key == K_C)) begin
                        clear_req = 1'b1;
`ifdef CALC_MEMORY_EN
                    end else if (!bus.key_type && (bus.key == K_E)) begin
                        mem_d      = op0_q;
                        mem_sign_d = sign0_q;
                        latch_d    = 1'b1;
                    end else if (!bus.key_type && (bus.key == K_D)) begin
                        if (ret_op1_q) begin
                            op1_d = mem_q; sign1_d = mem_sign_q; cnt1_d = CNT_FULL;
                        end else begin
                            op0_d = mem_q; sign0_d = mem_sign_q; cnt0_d = CNT_FULL;
                        end
                        latch_d = 1'b1;
`endif
                    end
                end
            end
            S_ERROR: begin
                if (accept && !bus.key_type && (bus.key == K_C)) clear_req = 1'b1;
            end
            default: state_d = S_LOAD_OP0;
        endcase

        // Clear leaves brightness (and memory) untouched
        if (clear_req) begin
            op0_d   = '0;
            op1_d   = '0;
            sign0_d = 1'b0;
            sign1_d = 1'b0;
            oper_d  = OP_SUM;
            cnt0_d  = '0;
            cnt1_d  = '0;
            pend_d  = 1'b0;
            state_d = S_LOAD_OP0;
            latch_d = 1'b1;
        end

        disp_mode_d = (state_d == S_ERROR);
        if (state_d == S_ERROR) begin
            disp_num_d  = '0;
            disp_sign_d = 1'b0;
        end else if (state_d == S_LOAD_OP1) begin
            disp_num_d  = op1_d;
            disp_sign_d = sign1_d;
        end else begin
            disp_num_d  = op0_d;
            disp_sign_d = sign0_d;
        end

        case (state_d)
            S_LOAD_OP0: led_d = 4'b0001;
            S_LOAD_OP1: led_d = 4'b0010;
            S_ERROR:    led_d = 4'b0100;
            S_MENU:     led_d = 4'b1000;
            default:    led_d = 4'b0000;
        endcase
    end

    // Datapath and output registers; armed_q clears while a key is held so a
    // key held through reset release needs a release before it is accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op0_q       <= '0;
            op1_q       <= '0;
            sign0_q     <= 1'b0;
            sign1_q     <= 1'b0;
            oper_q      <= OP_SUM;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            wait_q      <= '0;
            pend_q      <= 1'b0;
            pend_sub_q  <= 1'b0;
            ret_op1_q   <= 1'b0;
            armed_q     <= 1'b0;
            disp_num_q  <= '0;
            disp_sign_q <= 1'b0;
            disp_mode_q <= 1'b0;
            latch_q     <= 1'b0;
            bright_q    <= 4'(BRIGHT_RST);
            led_q       <= 4'b0001;
`ifdef CALC_MEMORY_EN
            mem_q       <= '0;
            mem_sign_q  <= 1'b0;
`endif
        end else begin
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            sign0_q     <= sign0_d;
            sign1_q     <= sign1_d;
            oper_q      <= oper_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            pend_sub_q  <= pend_sub_d;
            ret_op1_q   <= ret_op1_d;
            armed_q     <= !bus.key_valid;
            disp_num_q  <= disp_num_d;
            disp_sign_q <= disp_sign_d;
            disp_mode_q <= disp_mode_d;
            latch_q     <= latch_d;
            bright_q    <= bright_d;
            led_q       <= led_d;
`ifdef CALC_MEMORY_EN
            mem_q       <= mem_d;
            mem_sign_q  <= mem_sign_d;
`endif
        end
    end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: decimal-arithmetic model of the calculator checked every cycle,
// a delayed signed-BCD ALU, and directed key sequences with literal expectations.
module tb_calc_seq_ctrl;
    localparam int unsigned DN  = 8;
    localparam int unsigned LAT = 3;
    localparam int unsigned BR  = 4;
    localparam longint      LIMIT = 100000000;

    typedef enum {M_OP0, M_OP1, M_WAIT, M_MENU, M_ERR} mst_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    calc_seq_ctrl_if #(.DIGIT_NUM(DN)) bus ();
    calc_seq_ctrl #(.DIGIT_NUM(DN), .ALU_LATENCY(LAT), .BRIGHT_RST(BR)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    int n_cmp = 0, n_bad = 0, n_latch = 0;
    bit chk_en = 1'b0, ov_force = 1'b0;

    // Model state: operands as plain decimal integers plus typed digit counts
    longint m_v[2];
    int     m_cnt[2];
    bit     m_s[2];
    int     m_op, m_bright, wait_left;
    bit     m_ret1, m_pend, m_psub, exp_latch;
    mst_t   m_st;

    function automatic longint bcd2int(input logic [31:0] b);
        longint v = 0;
        for (int i = 7; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v);
        logic [31:0] b = '0;
        longint t = v;
        for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    // ALU: signed BCD add/sub, result delayed so it settles LAT cycles after its inputs
    longint a_in, b_in, r_in, mag_in;
    logic [33:0] alu_now, pipe0 = '0, pipe1 = '0;
    always_comb begin
        a_in    = bus.operand0_sign ? -bcd2int(bus.operand0) : bcd2int(bus.operand0);
        b_in    = bus.operand1_sign ? -bcd2int(bus.operand1) : bcd2int(bus.operand1);
        r_in    = (bus.operation == 3'b001) ? a_in - b_in : a_in + b_in;
        mag_in  = (r_in < 0) ? -r_in : r_in;
        alu_now = {ov_force || (mag_in >= LIMIT), r_in < 0, int2bcd(mag_in % LIMIT)};
    end
    always @(posedge clock) begin
        pipe0 <= alu_now;
        pipe1 <= pipe0;
    end
    assign bus.alu_flag_ov     = pipe1[33];
    assign bus.alu_result_sign = pipe1[32];
    assign bus.alu_result      = pipe1[31:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_led();
        case (m_st)
            M_OP0:   return 4'b0001;
            M_OP1:   return 4'b0010;
            M_ERR:   return 4'b0100;
            M_MENU:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (bus.disp_latch === 1'b1) n_latch++;
        if (chk_en) begin
            check("operand0", 64'(bus.operand0), 64'(int2bcd(m_v[0])));
            check("operand1", 64'(bus.operand1), 64'(int2bcd(m_v[1])));
            check("operand0_sign", 64'(bus.operand0_sign), 64'(m_s[0]));
            check("operand1_sign", 64'(bus.operand1_sign), 64'(m_s[1]));
            check("operation", 64'(bus.operation), 64'(m_op));
            check("brightness", 64'(bus.brightness), 64'(m_bright));
            check("state_led", 64'(bus.state_led), 64'(exp_led()));
            check("disp_latch", 64'(bus.disp_latch), 64'(exp_latch));
            check("disp_mode", 64'(bus.disp_mode), 64'(m_st == M_ERR));
            check("disp_num", 64'(bus.disp_num),
                  (m_st == M_ERR) ? 64'd0 : 64'(int2bcd((m_st == M_OP1) ? m_v[1] : m_v[0])));
            check("disp_sign", 64'(bus.disp_sign),
                  (m_st == M_ERR) ? 64'd0 : 64'((m_st == M_OP1) ? m_s[1] : m_s[0]));
        end
    end

    task automatic model_clear();
        m_v[0] = 0; m_v[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_s[0] = 0; m_s[1] = 0;
        m_op = 0; m_pend = 0; m_st = M_OP0; exp_latch = 1'b1;
    endtask

    task automatic model_reset();
        model_clear();
        m_bright = BR; m_ret1 = 0; m_psub = 0; wait_left = 0; exp_latch = 1'b0;
    endtask

    task automatic model_alu_done();
        longint a, b, r, mag;
        a = m_s[0] ? -m_v[0] : m_v[0];
        b = m_s[1] ? -m_v[1] : m_v[1];
        r = (m_op == 1) ? a - b : a + b;
        mag = (r < 0) ? -r : r;
        exp_latch = 1'b1;
        if (ov_force || mag >= LIMIT) begin
            m_st = M_ERR;
        end else begin
            m_v[0] = mag; m_s[0] = (r < 0); m_cnt[0] = DN;
            m_v[1] = 0;   m_s[1] = 0;       m_cnt[1] = 0;
            m_st = m_pend ? M_OP1 : M_OP0;
            if (m_pend) m_op = m_psub ? 1 : 0;
            m_pend = 0;
        end
    endtask

    task automatic model_accept(input bit kt, input int k);
        int s;
        exp_latch = 1'b0;
        case (m_st)
            M_OP0, M_OP1: begin
                s = (m_st == M_OP1) ? 1 : 0;
                if (kt) begin
                    if (k <= 9 && m_cnt[s] < DN) begin
                        m_v[s] = m_v[s] * 10 + k; m_cnt[s]++; exp_latch = 1'b1;
                    end
                end else if (k == 14) begin
                    if (m_cnt[s] > 0) begin m_v[s] = m_v[s] / 10; m_cnt[s]--; exp_latch = 1'b1; end
                end else if (k == 10 || k == 11) begin
                    exp_latch = 1'b1;
                    if (m_v[s] == 0) m_s[s] = !m_s[s];
                    else if (s == 0) begin m_op = (k == 11) ? 1 : 0; m_st = M_OP1; end
                    else begin m_pend = 1; m_psub = (k == 11); m_st = M_WAIT; wait_left = LAT; end
                end else if (k == 13) begin
                    if (s == 1 && m_v[1] != 0) begin
                        m_pend = 0; m_st = M_WAIT; wait_left = LAT; exp_latch = 1'b1;
                    end
                end else if (k == 12) begin
                    model_clear();
                end else if (k == 15) begin
                    m_ret1 = (s == 1); m_st = M_MENU; exp_latch = 1'b1;
                end
            end
            M_MENU: begin
                if (kt && k <= 7) begin m_bright = 2 * k; exp_latch = 1'b1; end
                else if (!kt && k == 15) begin m_st = m_ret1 ? M_OP1 : M_OP0; exp_latch = 1'b1; end
                else if (!kt && k == 12) model_clear();
            end
            M_ERR: if (!kt && k == 12) model_clear();
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        exp_latch = 1'b0;
        if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) model_alu_done();
        end
    endtask

    task automatic press(input bit kt, input logic [3:0] k, input int hold = 1);
        @(negedge clock);
        bus.key_type = kt; bus.key = k; bus.key_valid = 1'b1;
        @(posedge clock);
        model_accept(kt, int'(k));
        for (int c = 1; c < hold; c++) tick();
        @(negedge clock);
        bus.key_valid = 1'b0;
        tick();
        for (int g = 0; g < 64 && (wait_left > 0 || exp_latch); g++) tick();
    endtask

    task automatic dig(input logic [3:0] k); press(1'b1, k, 1); endtask
    task automatic sym(input logic [3:0] k); press(1'b0, k, 1); endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int n0;
        bus.key_valid = 1'b0; bus.key_type = 1'b0; bus.key = 4'h0;
        model_reset();
        #1 reset = 1'b1;
        @(negedge clock); chk_en = 1'b1;
        @(negedge clock); reset = 1'b0;
        tick(); tick();
        @(negedge clock);
        lit("rst_led", 64'(bus.state_led), 64'h1);
        lit("rst_bright", 64'(bus.brightness), 64'd4);
        lit("rst_op0", 64'(bus.operand0), 64'h0);

        // Entry, edge detection on a held key
        n0 = n_latch;
        dig(4'd1); dig(4'd2); press(1'b1, 4'd3, 10);
        @(negedge clock);
        lit("lit_op0_123", 64'(bus.operand0), 64'h123);
        lit("lit_latch3", 64'(n_latch - n0), 64'd3);

        // Digit limit and backspace
        sym(4'hC);
        repeat (9) dig(4'd1);
        @(negedge clock);
        lit("lit_9ones", 64'(bus.operand0), 64'h11111111);
        sym(4'hE);
        @(negedge clock);
        lit("lit_bksp", 64'(bus.operand0), 64'h01111111);

        // 5 + 3 with a three-cycle ALU
        sym(4'hC); dig(4'd5); sym(4'hA); dig(4'd3); sym(4'hD);
        @(negedge clock);
        lit("lit_5p3", 64'(bus.operand0), 64'h8);
        lit("lit_5p3_led", 64'(bus.state_led), 64'h1);

        // Chaining: 7 - 2, then A
        sym(4'hC); dig(4'd7); sym(4'hB); dig(4'd2); sym(4'hA);
        @(negedge clock);
        lit("lit_chain_op0", 64'(bus.operand0), 64'h5);
        lit("lit_chain_oper", 64'(bus.operation), 64'h0);
        lit("lit_chain_led", 64'(bus.state_led), 64'h2);
        lit("lit_chain_op1", 64'(bus.operand1), 64'h0);
        dig(4'd9); sym(4'hB); sym(4'hA); dig(4'd2); dig(4'd0); sym(4'hD);
        @(negedge clock);
        lit("lit_14m_neg20", 64'(bus.operand0), 64'h34);

        // Negative result, backspace on a result, signed addition
        sym(4'hC); dig(4'd3); sym(4'hB); dig(4'd8); sym(4'hD);
        @(negedge clock);
        lit("lit_neg5", 64'(bus.operand0), 64'h5);
        lit("lit_neg5_sign", 64'(bus.disp_sign), 64'h1);
        sym(4'hE); dig(4'd4); sym(4'hA); dig(4'd6); sym(4'hD);
        @(negedge clock);
        lit("lit_m4p6", 64'(bus.operand0), 64'h2);
        lit("lit_m4p6_sign", 64'(bus.operand0_sign), 64'h0);

        // D ignored in OP0, sign toggle on empty operand1
        sym(4'hC); dig(4'd2); sym(4'hD); sym(4'hA); sym(4'hA);
        @(negedge clock);
        lit("lit_sign1", 64'(bus.operand1_sign), 64'h1);

        // Forced and natural overflow
        sym(4'hC); dig(4'd1); sym(4'hA); dig(4'd2);
        ov_force = 1'b1;
        sym(4'hD);
        @(negedge clock);
        lit("lit_err_mode", 64'(bus.disp_mode), 64'h1);
        lit("lit_err_led", 64'(bus.state_led), 64'h4);
        dig(4'd5);
        ov_force = 1'b0;
        sym(4'hC);
        @(negedge clock);
        lit("lit_err_clr", 64'(bus.disp_mode), 64'h0);
        repeat (8) dig(4'd9);
        sym(4'hA); dig(4'd1); sym(4'hD);
        @(negedge clock);
        lit("lit_nat_ov", 64'(bus.state_led), 64'h4);
        sym(4'hC);

        // Brightness menu from each origin
        sym(4'hF); dig(4'd5); sym(4'hF);
        @(negedge clock);
        lit("lit_bright10", 64'(bus.brightness), 64'd10);
        lit("lit_menu_ret0", 64'(bus.state_led), 64'h1);
        dig(4'd1); sym(4'hA); sym(4'hF); dig(4'd8); dig(4'd7); sym(4'hE); sym(4'hD); sym(4'hF);
        @(negedge clock);
        lit("lit_bright14", 64'(bus.brightness), 64'd14);
        lit("lit_menu_ret1", 64'(bus.state_led), 64'h2);
        sym(4'hF); dig(4'd0); sym(4'hF); sym(4'hF); sym(4'hC);

        // Reset during WAIT_ALU
        dig(4'd1); sym(4'hA); dig(4'd1);
        @(negedge clock);
        bus.key_type = 1'b0; bus.key = 4'hD; bus.key_valid = 1'b1;
        @(posedge clock);
        model_accept(1'b0, 13);
        @(negedge clock);
        bus.key_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        model_reset();
        tick();
        @(negedge clock);
        lit("lit_rst_wait", 64'(bus.state_led), 64'h1);
        reset = 1'b0;
        repeat (LAT + 1) tick();

        // Key held through reset release is not accepted
        @(negedge clock);
        bus.key_type = 1'b1; bus.key = 4'd5; bus.key_valid = 1'b1;
        reset = 1'b1;
        model_reset();
        tick(); tick();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        bus.key_valid = 1'b0;
        tick();
        @(negedge clock);
        lit("lit_held_rst", 64'(bus.operand0), 64'h0);
        dig(4'd5);
        @(negedge clock);
        lit("lit_after_rel", 64'(bus.operand0), 64'h5);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
